// File: rtl/wac_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wac_bram_arbiter
// Purpose  : Two-requester arbiter/sequencer for BRAM port B. Beats are
//            registered onto the port with a synchronous enable, read data
//            is returned through a fixed-latency valid pipeline, ownership
//            is round-robin on ties and bounded by MAX_OWN cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wac_bram_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 8,
    parameter int RD_LAT  = 1,
    parameter int MAX_OWN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          last0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          last1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout,
    output logic          busy,
    output logic          own_err
);

    localparam int CW = (MAX_OWN > 1) ? $clog2(MAX_OWN) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(MAX_OWN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            prev_q, prev_d;    // 1: requester 1 owned last
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;    // final beat already taken on entry
    logic            gnt0_w, gnt1_w, own_err_w;

    logic            bram_en_q, bram_we_q;
    logic [AW-1:0]   bram_addr_q;
    logic [DW-1:0]   bram_din_q;
    logic [RD_LAT:0] rpipe0_q, rpipe1_q;

    // State, round-robin history, ownership counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Arbitration, grants, release and forced-release decision
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        gnt0_w    = 1'b0;
        gnt1_w    = 1'b0;
        own_err_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 && (!req1 || prev_q)) begin
                    gnt0_w  = 1'b1;
                    state_d = ST_OWN0;
                    cnt_d   = '0;
                    done_d  = last0;
                end else if (req1) begin
                    gnt1_w  = 1'b1;
                    state_d = ST_OWN1;
                    cnt_d   = '0;
                    done_d  = last1;
                end
            end
            ST_OWN0: begin
                gnt0_w = req0 & ~done_q;
                if (done_q || (gnt0_w && last0)) begin
                    state_d = ST_IDLE;
                    prev_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d   = ST_IDLE;
                    prev_d    = 1'b0;
                    own_err_w = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_OWN1: begin
                gnt1_w = req1 & ~done_q;
                if (done_q || (gnt1_w && last1)) begin
                    state_d = ST_IDLE;
                    prev_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d   = ST_IDLE;
                    prev_d    = 1'b1;
                    own_err_w = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grants are combinational; reset suppresses them even with req high
    assign gnt0    = gnt0_w & rst_n;
    assign gnt1    = gnt1_w & rst_n;
    assign own_err = own_err_w;

    // Register the accepted beat onto port B for exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            bram_en_q <= gnt0 | gnt1;
            if (gnt0) begin
                bram_we_q   <= we0;
                bram_addr_q <= addr0;
                bram_din_q  <= wdata0;
            end else if (gnt1) begin
                bram_we_q   <= we1;
                bram_addr_q <= addr1;
                bram_din_q  <= wdata1;
            end else begin
                bram_we_q   <= 1'b0;
            end
        end
    end

    // Read-valid pipelines: 1 cycle to the port plus RD_LAT of BRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpipe0_q <= '0;
            rpipe1_q <= '0;
        end else begin
            rpipe0_q <= {rpipe0_q[RD_LAT-1:0], gnt0 & ~we0};
            rpipe1_q <= {rpipe1_q[RD_LAT-1:0], gnt1 & ~we1};
        end
    end

    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;
    assign rvalid0   = rpipe0_q[RD_LAT];
    assign rvalid1   = rpipe1_q[RD_LAT];
    assign rdata     = (rvalid0 | rvalid1) ? bram_dout : '0;
    assign busy      = (state_q != ST_IDLE) | (|rpipe0_q) | (|rpipe1_q) | bram_en_q;

endmodule
`default_nettype wire

// File: tb/tb_wac_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wac_bram_arbiter
// Purpose  : Two arbiter instances (MAX_OWN 64 and 8) share one stimulus
//            stream and are compared every cycle with an owner/queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wac_bram_arbiter;

    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic req0, we0, last0, req1, we1, last1;
    logic [11:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;

    logic [1:0] g0, g1, rv0, rv1, ben, bwe, bsy, oerr;
    logic [1:0][11:0] badr;
    logic [1:0][7:0]  bdin, rdat;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 29 + 5) ^ (i >> 3));
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [7:0] mem [4096];
        logic [7:0] dout;
        wac_bram_arbiter #(
            .AW(12), .DW(8), .RD_LAT(RD_LAT), .MAX_OWN(gi == 0 ? 64 : 8)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .last0(last0),
            .gnt0(g0[gi]), .rvalid0(rv0[gi]),
            .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .last1(last1),
            .gnt1(g1[gi]), .rvalid1(rv1[gi]),
            .rdata(rdat[gi]),
            .bram_en(ben[gi]), .bram_we(bwe[gi]), .bram_addr(badr[gi]),
            .bram_din(bdin[gi]), .bram_dout(dout),
            .busy(bsy[gi]), .own_err(oerr[gi])
        );
        // Behavioural 1-cycle synchronous BRAM on port B
        always @(posedge clk) begin
            if (cyc == 0) begin
                for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
            end else if (ben[gi]) begin
                if (bwe[gi]) mem[badr[gi]] <= bdin[gi];
                else         dout <= mem[badr[gi]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model (owner + scheduled returns) ----------
    int          own  [2];   // 0 none, 1 requester 0, 2 requester 1
    int          prev [2];
    int          cnt  [2];
    bit          done [2];
    logic        e_en [2];
    logic        e_we [2];
    logic [11:0] e_adr[2];
    logic [7:0]  e_din[2];
    bit          pv [2][8];
    int          pw [2][8];
    logic [7:0]  pd [2][8];
    logic [7:0]  ref_m [2][4096];

    task automatic model_step(input int k);
        logic r[2], w[2], l[2];
        logic [11:0] a[2];
        logic [7:0]  d[2];
        int win, slot, mx;
        bit anyp;
        logic x_g0, x_g1, x_rv0, x_rv1, x_err, x_busy;
        logic [7:0] x_rd;
        string p;
        p = $sformatf("u%0d", k);
        mx = (k == 0) ? 64 : 8;
        r[0] = req0; w[0] = we0; l[0] = last0; a[0] = addr0; d[0] = wdata0;
        r[1] = req1; w[1] = we1; l[1] = last1; a[1] = addr1; d[1] = wdata1;
        if (!rst_n) begin
            own[k] = 0; prev[k] = 1; cnt[k] = 0; done[k] = 0;
            e_en[k] = 0; e_we[k] = 0; e_adr[k] = '0; e_din[k] = '0;
            for (int s = 0; s < 8; s++) pv[k][s] = 0;
            chk({p, " rst gnt"},  32'({g0[k], g1[k]}), 32'd0);
            chk({p, " rst rv"},   32'({rv0[k], rv1[k]}), 32'd0);
            chk({p, " rst rdata"}, 32'(rdat[k]), 32'd0);
            chk({p, " rst port"}, {ben[k], bwe[k], badr[k], bdin[k]}, 32'd0);
            chk({p, " rst busy/err"}, 32'({bsy[k], oerr[k]}), 32'd0);
            return;
        end
        // beat sitting on the port executes at the coming edge
        if (e_en[k]) begin
            if (e_we[k]) ref_m[k][e_adr[k]] = e_din[k];
            else pd[k][(cyc + RD_LAT) % 8] = ref_m[k][e_adr[k]];
        end
        win = -1;
        if (own[k] == 0) begin
            if (r[0] && r[1]) win = (prev[k] == 1) ? 0 : 1;
            else if (r[0])    win = 0;
            else if (r[1])    win = 1;
        end else if (!done[k] && r[own[k] - 1]) begin
            win = own[k] - 1;
        end
        x_g0  = (win == 0);
        x_g1  = (win == 1);
        x_err = (own[k] != 0) && !done[k] && (cnt[k] == mx - 1) && !(win >= 0 && l[win]);
        slot  = cyc % 8;
        anyp  = 0;
        for (int s = 0; s < 8; s++) anyp |= pv[k][s];
        x_rv0  = pv[k][slot] && (pw[k][slot] == 0);
        x_rv1  = pv[k][slot] && (pw[k][slot] == 1);
        x_rd   = pv[k][slot] ? pd[k][slot] : 8'h00;
        x_busy = (own[k] != 0) || e_en[k] || anyp;
        chk({p, " gnt0"}, 32'(g0[k]), 32'(x_g0));
        chk({p, " gnt1"}, 32'(g1[k]), 32'(x_g1));
        chk({p, " rvalid0"}, 32'(rv0[k]), 32'(x_rv0));
        chk({p, " rvalid1"}, 32'(rv1[k]), 32'(x_rv1));
        chk({p, " rdata"}, 32'(rdat[k]), 32'(x_rd));
        chk({p, " bram_en"}, 32'(ben[k]), 32'(e_en[k]));
        chk({p, " bram_we"}, 32'(bwe[k]), 32'(e_we[k]));
        chk({p, " bram_addr"}, 32'(badr[k]), 32'(e_adr[k]));
        chk({p, " bram_din"}, 32'(bdin[k]), 32'(e_din[k]));
        chk({p, " busy"}, 32'(bsy[k]), 32'(x_busy));
        chk({p, " own_err"}, 32'(oerr[k]), 32'(x_err));
        pv[k][slot] = 0;
        // advance: what the port carries next cycle
        if (win >= 0) begin
            e_en[k] = 1; e_we[k] = w[win]; e_adr[k] = a[win]; e_din[k] = d[win];
            if (!w[win]) begin
                pv[k][(cyc + 1 + RD_LAT) % 8] = 1;
                pw[k][(cyc + 1 + RD_LAT) % 8] = win;
            end
        end else begin
            e_en[k] = 0; e_we[k] = 0;
        end
        if (own[k] == 0) begin
            if (win >= 0) begin own[k] = win + 1; cnt[k] = 0; done[k] = l[win]; end
        end else if (done[k] || (win >= 0 && l[win]) || cnt[k] == mx - 1) begin
            prev[k] = own[k] - 1; own[k] = 0; done[k] = 0;
        end else begin
            cnt[k]++;
        end
    endtask

    // Compare on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (cyc == 0)
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 4096; i++) ref_m[k][i] = init_val(i);
        for (int k = 0; k < 2; k++) model_step(k);
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic [11:0] a,
                        input logic [7:0] d, input logic l);
        req0 = r; we0 = w; addr0 = a; wdata0 = d; last0 = l;
    endtask

    task automatic set1(input logic r, input logic w, input logic [11:0] a,
                        input logic [7:0] d, input logic l);
        req1 = r; we1 = w; addr1 = a; wdata1 = d; last1 = l;
    endtask

    initial begin
        int i, n;
        bit held, g;
        rst_n = 1'b0;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick(3);
        rst_n = 1'b1;

        // tie straight out of reset, both single-beat reads, alternating winner
        set0(1, 0, 12'h001, 8'h00, 1);
        set1(1, 0, 12'h002, 8'h00, 1);
        tick(6);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick(4);

        // single read then a three-beat command burst
        set0(1, 0, 12'h000, 8'h00, 1);
        tick(1);
        set0(0, 0, 0, 0, 0);
        tick(4);
        for (int b = 0; b < 3; b++) begin
            set0(1, 0, 12'(b), 8'h00, b == 2);
            tick(1);
        end
        set0(0, 0, 0, 0, 0);
        tick(4);

        // ADC burst 0x003..0x020 with a 5-cycle hold, command reader waiting
        i = 3; n = 0; held = 0;
        while (i <= 32 && n < 200) begin
            if (i == 10 && !held) begin
                held = 1;
                set1(0, 1, 12'(i), 8'h00, 0);
                tick(5);
            end
            set1(1, 1, 12'(i), 8'($urandom), i == 32);
            if (i > 3) set0(1, 0, 12'h000, 8'h00, 1);
            #1;
            g = g1[0];
            @(posedge clk);
            #1;
            if (g) i++;
            n++;
        end
        chk("adc burst completes", 32'(n < 200), 32'd1);
        set1(0, 0, 0, 0, 0);
        tick(2);
        set0(0, 0, 0, 0, 0);
        tick(5);
        for (int a = 3; a <= 32; a++)
            chk($sformatf("adc image %0h", a), 32'(g_inst[0].mem[a]), 32'(ref_m[0][a]));

        // ownership without last: the MAX_OWN=8 instance is forced to release
        set1(1, 1, 12'h100, 8'hA5, 0);
        tick(1);
        set0(1, 0, 12'h001, 8'h00, 1);
        tick(14);
        set1(1, 1, 12'h101, 8'h5A, 1);
        tick(1);
        set1(0, 0, 0, 0, 0);
        tick(2);
        // reset while a read is in flight
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        set0(0, 0, 0, 0, 0);
        tick(5);

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            set0(($urandom % 4) != 0, $urandom % 2, 12'($urandom_range(0, 63)),
                 8'($urandom), ($urandom % 6) == 0);
            set1(($urandom % 3) != 0, $urandom % 2, 12'($urandom_range(0, 63)),
                 8'($urandom), ($urandom % 12) == 0);
            rst_n = ($urandom % 300) != 0;
            tick(1);
        end
        rst_n = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
